dmem_bridge: RTL

- Sits directly downstream of the processor's data-memory port (rd_enb / wr_enb / addr / wr_data / rd_data).
- Adapts that port to a slower external data SRAM with a req/ack handshake.
- Absorbs stores into a small in-order write buffer and forwards buffered data to later loads.
- Issues load misses to external memory, giving them priority over pending buffered writes.

---
 rtl/dmem_bridge_pkg.sv | 19 +
 rtl/dmem_wbuf.sv | 91 +++++++++
 rtl/dmem_bridge.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/dmem_bridge_pkg.sv
// Shared types and constants for the data-memory bridge: FSM encoding,
// default widths and the write-buffer pointer-width helper.
package dmem_bridge_pkg;

  localparam int DEF_ADDR_W   = 8;
  localparam int DEF_DATA_W   = 8;
  localparam int DEF_WB_DEPTH = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WR_REQ = 2'd1,
    ST_RD_REQ = 2'd2
  } state_e;

  function automatic int wb_ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/dmem_wbuf.sv
// In-order circular write buffer with a combinational youngest-match lookup
// over the entries present at the start of the cycle.
module dmem_wbuf
  import dmem_bridge_pkg::*;
#(
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int DATA_W   = DEF_DATA_W,
  parameter int WB_DEPTH = DEF_WB_DEPTH,
  localparam int PTR_W   = wb_ptr_w(WB_DEPTH),
  localparam int CNT_W   = PTR_W + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_push,
  input  logic [ADDR_W-1:0] i_push_addr,
  input  logic [DATA_W-1:0] i_push_data,
  input  logic              i_pop,
  input  logic [ADDR_W-1:0] i_lookup_addr,
  output logic [ADDR_W-1:0] o_head_addr,
  output logic [DATA_W-1:0] o_head_data,
  output logic [CNT_W-1:0]  o_count,
  output logic              o_full,
  output logic              o_empty,
  output logic              o_hit,
  output logic [DATA_W-1:0] o_hit_data
);

  logic [ADDR_W-1:0] r_addr_q [WB_DEPTH];
  logic [DATA_W-1:0] r_data_q [WB_DEPTH];
  logic [PTR_W-1:0]  r_head;
  logic [PTR_W-1:0]  r_tail;
  logic [CNT_W-1:0]  r_count;

  logic              w_do_push;
  logic              w_do_pop;
  logic [WB_DEPTH-1:0] w_match;
  logic              w_hit;
  logic [DATA_W-1:0] w_hit_data;

  assign o_full      = (r_count == CNT_W'(WB_DEPTH));
  assign o_empty     = (r_count == {CNT_W{1'b0}});
  assign o_count     = r_count;
  assign o_head_addr = r_addr_q[r_head];
  assign o_head_data = r_data_q[r_head];
  assign o_hit       = w_hit;
  assign o_hit_data  = w_hit_data;

  assign w_do_push = i_push & ~o_full;
  assign w_do_pop  = i_pop & ~o_empty;

  // Entry storage, pointers and occupancy count
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_head  <= {PTR_W{1'b0}};
      r_tail  <= {PTR_W{1'b0}};
      r_count <= {CNT_W{1'b0}};
      for (int i = 0; i < WB_DEPTH; i++) begin
        r_addr_q[i] <= {ADDR_W{1'b0}};
        r_data_q[i] <= {DATA_W{1'b0}};
      end
    end else begin
      if (w_do_push) begin
        r_addr_q[r_tail] <= i_push_addr;
        r_data_q[r_tail] <= i_push_data;
        r_tail           <= r_tail + 1'b1;
      end
      if (w_do_pop) begin
        r_head <= r_head + 1'b1;
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Walk oldest to youngest so the last match seen wins
  always_comb begin
    w_match    = {WB_DEPTH{1'b0}};
    w_hit      = 1'b0;
    w_hit_data = {DATA_W{1'b0}};
    for (int i = 0; i < WB_DEPTH; i++) begin
      w_match[i] = (CNT_W'(i) < r_count) &&
                   (r_addr_q[r_head + PTR_W'(i)] == i_lookup_addr);
      w_hit_data = w_match[i] ? r_data_q[r_head + PTR_W'(i)] : w_hit_data;
      w_hit      = w_hit | w_match[i];
    end
  end

endmodule

// File: rtl/dmem_bridge.sv
// Bridges the processor data-memory port to a req/ack external SRAM, with a
// forwarding write buffer and read-over-write priority for load misses.
module dmem_bridge
  import dmem_bridge_pkg::*;
#(
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int DATA_W   = DEF_DATA_W,
  parameter int WB_DEPTH = DEF_WB_DEPTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              data_mem_rd_enb_i,
  input  logic              data_mem_wr_enb_i,
  input  logic [ADDR_W-1:0] data_mem_addr_i,
  input  logic [DATA_W-1:0] data_mem_wr_data_i,
  output logic [DATA_W-1:0] data_mem_rd_data_o,
  output logic              data_mem_rd_valid_o,
  output logic              data_mem_busy_o,
  output logic              proto_err_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic              mem_ack_i,
  input  logic [DATA_W-1:0] mem_rdata_i
);

  localparam int PTR_W = wb_ptr_w(WB_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  state_e            r_state;
  logic              r_rd_pending;
  logic [ADDR_W-1:0] r_rd_addr;
  logic [DATA_W-1:0] r_rd_data;
  logic              r_rd_valid;
  logic              r_busy;
  logic              r_proto_err;
  logic              r_mem_req;
  logic              r_mem_we;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata;

  logic              w_ack;
  logic              w_push;
  logic              w_pop;
  logic              w_load_ok;
  logic              w_hit_load;
  logic              w_miss_load;
  logic              w_err;
  logic              w_hit;
  logic [DATA_W-1:0] w_hit_data;
  logic [ADDR_W-1:0] w_head_addr;
  logic [DATA_W-1:0] w_head_data;
  logic [CNT_W-1:0]  w_count;
  logic [CNT_W-1:0]  w_count_next;
  logic              w_full;
  logic              w_empty;
  logic              w_rd_pending_next;
  logic              w_busy_next;

  dmem_wbuf #(
    .ADDR_W   (ADDR_W),
    .DATA_W   (DATA_W),
    .WB_DEPTH (WB_DEPTH)
  ) u_wbuf (
    .clk           (clk),
    .rst           (rst),
    .i_push        (w_push),
    .i_push_addr   (data_mem_addr_i),
    .i_push_data   (data_mem_wr_data_i),
    .i_pop         (w_pop),
    .i_lookup_addr (data_mem_addr_i),
    .o_head_addr   (w_head_addr),
    .o_head_data   (w_head_data),
    .o_count       (w_count),
    .o_full        (w_full),
    .o_empty       (w_empty),
    .o_hit         (w_hit),
    .o_hit_data    (w_hit_data)
  );

  // An ack is meaningful only while a request is actually outstanding
  assign w_ack       = mem_ack_i & r_mem_req;
  assign w_pop       = (r_state == ST_WR_REQ) & w_ack;
  assign w_push      = data_mem_wr_enb_i & ~r_busy & ~w_full;
  assign w_load_ok   = data_mem_rd_enb_i & ~data_mem_wr_enb_i & ~r_busy;
  assign w_hit_load  = w_load_ok & w_hit;
  assign w_miss_load = w_load_ok & ~w_hit;
  assign w_err       = (data_mem_rd_enb_i & data_mem_wr_enb_i) |
                       ((data_mem_rd_enb_i | data_mem_wr_enb_i) & r_busy);

  // Next-cycle occupancy and pending-miss flag feed the registered busy
  always_comb begin
    w_count_next      = w_count;
    w_rd_pending_next = r_rd_pending;
    if (w_push && !w_pop) begin
      w_count_next = w_count + CNT_W'(1);
    end else if (!w_push && w_pop) begin
      w_count_next = w_count - CNT_W'(1);
    end else begin
      w_count_next = w_count;
    end
    if (w_miss_load) begin
      w_rd_pending_next = 1'b1;
    end else if ((r_state == ST_RD_REQ) && w_ack) begin
      w_rd_pending_next = 1'b0;
    end else begin
      w_rd_pending_next = r_rd_pending;
    end
    w_busy_next = (w_count_next == CNT_W'(WB_DEPTH)) | w_rd_pending_next;
  end

  // Transaction FSM with all port-facing outputs registered
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= ST_IDLE;
      r_rd_pending <= 1'b0;
      r_rd_addr    <= {ADDR_W{1'b0}};
      r_rd_data    <= {DATA_W{1'b0}};
      r_rd_valid   <= 1'b0;
      r_busy       <= 1'b0;
      r_proto_err  <= 1'b0;
      r_mem_req    <= 1'b0;
      r_mem_we     <= 1'b0;
      r_mem_addr   <= {ADDR_W{1'b0}};
      r_mem_wdata  <= {DATA_W{1'b0}};
    end else begin
      r_rd_valid   <= 1'b0;
      r_proto_err  <= w_err;
      r_busy       <= w_busy_next;
      r_rd_pending <= w_rd_pending_next;
      if (w_miss_load) begin
        r_rd_addr <= data_mem_addr_i;
      end
      if (w_hit_load) begin
        r_rd_data  <= w_hit_data;
        r_rd_valid <= 1'b1;
      end
      case (r_state)
        ST_IDLE: begin
          if (r_rd_pending) begin
            r_state    <= ST_RD_REQ;
            r_mem_req  <= 1'b1;
            r_mem_we   <= 1'b0;
            r_mem_addr <= r_rd_addr;
          end else if (!w_empty) begin
            r_state     <= ST_WR_REQ;
            r_mem_req   <= 1'b1;
            r_mem_we    <= 1'b1;
            r_mem_addr  <= w_head_addr;
            r_mem_wdata <= w_head_data;
          end else begin
            r_state   <= ST_IDLE;
            r_mem_req <= 1'b0;
          end
        end
        ST_WR_REQ: begin
          if (w_ack) begin
            r_state   <= ST_IDLE;
            r_mem_req <= 1'b0;
            r_mem_we  <= 1'b0;
          end
        end
        ST_RD_REQ: begin
          if (w_ack) begin
            r_state    <= ST_IDLE;
            r_mem_req  <= 1'b0;
            r_rd_data  <= mem_rdata_i;
            r_rd_valid <= 1'b1;
          end
        end
        default: begin
          r_state   <= ST_IDLE;
          r_mem_req <= 1'b0;
          r_mem_we  <= 1'b0;
        end
      endcase
    end
  end

  assign data_mem_rd_data_o  = r_rd_data;
  assign data_mem_rd_valid_o = r_rd_valid;
  assign data_mem_busy_o     = r_busy;
  assign proto_err_o         = r_proto_err;
  assign mem_req_o           = r_mem_req;
  assign mem_we_o            = r_mem_we;
  assign mem_addr_o          = r_mem_addr;
  assign mem_wdata_o         = r_mem_wdata;

endmodule
